gcd_ci_multi: RTL and testbench
===============================

# gcd_ci_multi

Parametrised multicycle GCD engine for Nios II custom-instruction use, successor to the fixed-width `gcd_ci`. It computes the greatest common divisor of two unsigned WIDTH-bit operands using a one-step-per-cycle binary (Stein) algorithm. An extended-opcode field `n` selects what is returned: the GCD, a coprime flag, or the cycle count of the operation. It attaches to the processor's custom-instruction slave port with the standard `clk_en`/`start`/`done` handshake.

## Interface
- `WIDTH`, 32: operand and result width in bits, ≥ 4.
- `CNT_WIDTH`, $clog2(4*WIDTH+8): width of the internal cycle counter.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `clk_en` in 1: when 0, all state, counters and outputs hold.
- `start` in 1: operation request, sampled only in IDLE with `clk_en`=1.
- `n` in 2: mode, captured with `start`. 0 = GCD, 1 = coprime flag, 2 = cycle count, 3 = GCD.
- `dataa` in WIDTH: operand A (unsigned), captured with `start`.
- `datab` in WIDTH: operand B (unsigned), captured with `start`.
- `done` out 1: one-cycle pulse marking `result` valid.
- `busy` out 1: high from the cycle after `start` is accepted through the DONE cycle.
- `result` out WIDTH: output selected by the captured mode. Held until the next accepted `start`.

## Operation
- Internal registers: A, B (WIDTH), shift count K, cycle count C (CNT_WIDTH), mode M.
- States: IDLE, STRIP, ODD, LOOP, DONE.
- IDLE:
  - If `start`=1 and either operand is 0: go directly to DONE with G = `dataa` | `datab`, C = 1.
  - If `start`=1 otherwise: load A, B, M; set K = 0, C = 1; go to STRIP.
- STRIP:
  - If A[0]=0 and B[0]=0: A>>=1, B>>=1, K++; stay in STRIP.
  - Otherwise go to ODD.
- ODD:
  - If A[0]=0: A>>=1; stay in ODD.
  - Otherwise go to LOOP.
- LOOP (A is always odd here):
  - If B=0: G = A<<K; go to DONE.
  - Else if B[0]=0: B>>=1.
  - Else: A ← min(A,B), B ← |A−B|. One unsigned WIDTH-bit comparator and subtractor.
- C increments on every advancing edge (`clk_en`=1) outside IDLE, including the edge that enters DONE. C saturates at all-ones.
- DONE:
  - `done`=1 for exactly one cycle; `result` is loaded on the edge entering DONE.
  - Next state is IDLE.
- Result by mode:
  - M=0 or 3: G.
  - M=1: 1 if G==1, else 0.
  - M=2: C, zero-extended.
- G(0,0)=0. G(0,x)=x.
- `start` asserted while busy is ignored; there is no queueing.
- If `start` is still high in the IDLE cycle after DONE, a new operation starts. Software and the bench deassert `start` by then.
- Reset mid-operation: the state returns to IDLE and the operation is discarded.

## Timing
- Reset values: `done`=0, `busy`=0, `result`=0, state IDLE, A=B=K=C=0.
- Edge 0 is the edge at which `start` is sampled.
- Zero operand: DONE is entered at edge 0; `done` is high in the cycle after edge 0; latency 1.
- Nonzero operands: latency = 1 (STRIP entry) + STRIP cycles + ODD cycles + LOOP cycles. Bounded by 4*WIDTH+4.
- Gated edges (`clk_en`=0) do not count toward latency or C.
- `result` is combinationally independent of inputs; it changes only on the edge entering DONE.
- `n`, `dataa` and `datab` may change freely after edge 0.

## Test plan
- Reset for 2 cycles, then (1,1) with n=0:
  - `done` is high in the cycle after edge 4.
  - `result`=1.
  - All outputs are 0 during reset.
- (91,21), n=0, then (91,21), n=2:
  - First run: `result`=7.
  - Second run: `result` equals the observed start-to-DONE edge count.
  - `done` is exactly one cycle wide.
- Boundary operands, n=0:
  - (0,0) → 0, (0,12) → 12, (1000000000,1) → 1.
  - Each zero-operand case completes in 1 cycle.
- Large operands, n=0, then n=1:
  - (2147483647,524287) → 1 with n=0.
  - (2,1023) with n=1 → 1.
  - (48,36) with n=1 → 0; n=0 gives 12 (K=2).
- Stalls and ignored requests on (91,21):
  - Toggle `clk_en` low for 3 cycles mid-LOOP: `result` is still 7, and C is unchanged by the stall.
  - Pulse `start` with new operands while `busy`: the request is ignored.
- Reset and width scaling:
  - Assert `reset_n`=0 mid-LOOP: state is IDLE next cycle, `busy`=0, `result`=0, no `done`.
  - Repeat the suite with WIDTH=8: (255,85) → 85.

Source files
------------

// File: rtl/gcd_ci_multi.sv
// gcd_ci_multi -- multicycle binary (Stein) GCD engine for a Nios II
// custom-instruction slave port. One algorithm step per enabled clock.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   clk_en   when low, every register holds
//   start    operation request, accepted only in IDLE
//   n        mode: 0/3 = GCD, 1 = coprime flag, 2 = cycle count
//   dataa    operand A (unsigned)
//   datab    operand B (unsigned)
//   done     one-cycle pulse, result valid
//   busy     high from the cycle after acceptance through the DONE cycle
//   result   mode-selected output, held until the next completion
module gcd_ci_multi #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = $clog2(4*WIDTH+8)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic [1:0]       n,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] result
);

  // K never exceeds WIDTH-1 because both operands are nonzero in STRIP.
  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STRIP,
    S_ODD,
    S_LOOP,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [KW-1:0]        r_k;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [1:0]           r_mode;
  logic                 r_done;
  logic                 r_busy;
  logic [WIDTH-1:0]     r_result;

  logic                 w_a_lt_b;
  logic [WIDTH-1:0]     w_big;
  logic [WIDTH-1:0]     w_small;
  logic [WIDTH-1:0]     w_diff;
  logic [CNT_WIDTH-1:0] w_cnt_inc;

  // Operands are steered into a single subtractor: |A-B| = max - min.
  assign w_a_lt_b  = r_a < r_b;
  assign w_big     = w_a_lt_b ? r_b : r_a;
  assign w_small   = w_a_lt_b ? r_a : r_b;
  assign w_diff    = w_big - w_small;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);

  assign done   = r_done;
  assign busy   = r_busy;
  assign result = r_result;

  function automatic logic [WIDTH-1:0] f_sel(input logic [1:0]           m,
                                             input logic [WIDTH-1:0]     g,
                                             input logic [CNT_WIDTH-1:0] c);
    logic [WIDTH-1:0] v;
    case (m)
      2'd1:    v = (g == WIDTH'(1)) ? WIDTH'(1) : '0;
      2'd2:    v = WIDTH'(c);
      default: v = g;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_mode   <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= '0;
    end else if (clk_en) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= n;
            r_busy <= 1'b1;
            r_cnt  <= CNT_WIDTH'(1);
            if (dataa == '0 || datab == '0) begin
              // GCD with a zero operand is the other operand (0 for 0,0).
              r_result <= f_sel(n, dataa | datab, CNT_WIDTH'(1));
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_a     <= dataa;
              r_b     <= datab;
              r_k     <= '0;
              r_state <= S_STRIP;
            end
          end
        end
        S_STRIP: begin
          r_cnt <= w_cnt_inc;
          if (!r_a[0] && !r_b[0]) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
            r_k <= r_k + KW'(1);
          end else begin
            r_state <= S_ODD;
          end
        end
        S_ODD: begin
          r_cnt <= w_cnt_inc;
          if (!r_a[0]) r_a <= r_a >> 1;
          else         r_state <= S_LOOP;
        end
        S_LOOP: begin
          r_cnt <= w_cnt_inc;
          if (r_b == '0) begin
            // Count reported in mode 2 includes this DONE-entry edge.
            r_result <= f_sel(r_mode, r_a << r_k, w_cnt_inc);
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (!r_b[0]) begin
            r_b <= r_b >> 1;
          end else begin
            r_a <= w_small;
            r_b <= w_diff;
          end
        end
        S_DONE: begin
          r_cnt   <= w_cnt_inc;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_ci_multi.sv
// tb_gcd_ci_multi -- scoreboard bench for gcd_ci_multi at WIDTH=32 and 8.
// Drivers push hand-computed expectations; monitors pop on every done pulse.
module tb_gcd_ci_multi;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, clk_en;
  logic        start, start8;
  logic [1:0]  n, n8;
  logic [31:0] dataa, datab, result;
  logic [7:0]  dataa8, datab8, result8;
  logic        done, busy, done8, busy8;

  gcd_ci_multi #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .done(done), .busy(busy), .result(result)
  );

  gcd_ci_multi #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start8), .n(n8),
    .dataa(dataa8), .datab(datab8), .done(done8), .busy(busy8), .result(result8)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;   // 0 = latency not checked
    int          e0;
    int          tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   en_edges = 0;
  int   dlen0    = 0;
  int   dlen1    = 0;

  always @(posedge clk) if (reset_n && clk_en) en_edges <= en_edges + 1;

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %0d, expected %0d", nm, tag, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (done) begin
      if (dlen0 == 0) begin
        if (q0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done w32: result %0d, expected no done", result);
        end else begin
          e = q0.pop_front();
          chk("result_w32", e.tag, result, e.res);
          if (e.lat != 0) chk("latency_w32", e.tag, en_edges - e.e0 + 1, e.lat);
        end
      end
      dlen0++;
    end else if (dlen0 != 0) begin
      chk("done_width_w32", 0, dlen0, 1);
      dlen0 = 0;
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done8) begin
      if (dlen1 == 0) begin
        if (q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done w8: result %0d, expected no done", result8);
        end else begin
          e = q1.pop_front();
          chk("result_w8", e.tag, {24'd0, result8}, e.res);
          if (e.lat != 0) chk("latency_w8", e.tag, en_edges - e.e0 + 1, e.lat);
        end
      end
      dlen1++;
    end else if (dlen1 != 0) begin
      chk("done_width_w8", 0, dlen1, 1);
      dlen1 = 0;
    end
  end

  task automatic run(input bit w8, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] md, input logic [31:0] er, input int el,
                     input int tag, input int stall_at, input bit poke);
    exp_t e;
    bit   pending;
    @(negedge clk);
    if (w8) begin dataa8 = a[7:0]; datab8 = b[7:0]; n8 = md; start8 = 1'b1; end
    else    begin dataa  = a;      datab  = b;      n  = md; start  = 1'b1; end
    @(posedge clk); #1;
    e.res = er; e.lat = el; e.e0 = en_edges; e.tag = tag;
    if (w8) q1.push_back(e); else q0.push_back(e);
    @(negedge clk);
    start = 1'b0; start8 = 1'b0;
    dataa = '1; datab = '1; n = 2'd3; dataa8 = '1; datab8 = '1; n8 = 2'd3;
    chk("busy_active", tag, {31'd0, w8 ? busy8 : busy}, 1);
    pending = 1'b1;
    for (int i = 0; i < 300 && pending; i++) begin
      if (stall_at != 0 && i == stall_at)     clk_en = 1'b0;
      if (stall_at != 0 && i == stall_at + 3) clk_en = 1'b1;
      if (poke && i == 2) begin start = 1'b1; dataa = 48; datab = 36; n = 2'd0; end
      if (poke && i == 3) start = 1'b0;
      @(negedge clk);
      pending = (w8 ? q1.size() : q0.size()) != 0;
    end
    clk_en = 1'b1;
    start  = 1'b0;
    if (pending) begin
      n_checks++; n_fail++;
      $display("FAIL timeout vec%0d: no done within 300 cycles, expected done", tag);
      if (w8) q1.delete(); else q0.delete();
    end
    @(negedge clk);
    chk("busy_idle", tag, {31'd0, w8 ? busy8 : busy}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; clk_en = 1'b1;
    start = 1'b0; n = '0; dataa = '0; datab = '0;
    start8 = 1'b0; n8 = '0; dataa8 = '0; datab8 = '0;
    @(negedge clk);
    chk("rst_done",   0, {31'd0, done},  0);
    chk("rst_busy",   0, {31'd0, busy},  0);
    chk("rst_result", 0, result,         0);
    chk("rst_done8",  0, {31'd0, done8}, 0);
    chk("rst_busy8",  0, {31'd0, busy8}, 0);
    chk("rst_result8",0, {24'd0, result8}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    //   w8  a           b       n  expect  lat tag stall poke
    run(0, 1,          1,      0, 1,      5,  1,  0,  0);
    run(0, 91,         21,     0, 7,      11, 2,  0,  0);
    run(0, 91,         21,     2, 11,     11, 3,  0,  0);
    run(0, 0,          0,      0, 0,      1,  4,  0,  0);
    run(0, 0,          12,     0, 12,     1,  5,  0,  0);
    run(0, 1000000000, 1,      0, 1,      0,  6,  0,  0);
    run(0, 2147483647, 524287, 0, 1,      0,  7,  0,  0);
    run(0, 2,          1023,   1, 1,      0,  8,  0,  0);
    run(0, 48,         36,     1, 0,      11, 9,  0,  0);
    run(0, 48,         36,     0, 12,     11, 10, 0,  0);
    run(0, 48,         36,     3, 12,     11, 11, 0,  0);
    run(0, 91,         21,     2, 11,     11, 12, 5,  0);
    run(0, 91,         21,     0, 7,      11, 13, 0,  1);
    run(0, 0,          5,      2, 1,      1,  14, 0,  0);
    run(0, 12,         0,      1, 0,      1,  15, 0,  0);
    run(0, 1,          0,      1, 1,      1,  16, 0,  0);

    // Reset in the middle of LOOP: the operation is dropped silently.
    @(negedge clk);
    dataa = 91; datab = 21; n = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy",   17, {31'd0, busy}, 0);
    chk("midrst_done",   17, {31'd0, done}, 0);
    chk("midrst_result", 17, result,        0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    run(0, 91,         21,     0, 7,      11, 18, 0,  0);

    run(1, 255,        85,     0, 85,     7,  20, 0,  0);
    run(1, 0,          0,      0, 0,      1,  21, 0,  0);
    run(1, 12,         18,     1, 0,      9,  22, 0,  0);
    run(1, 12,         18,     0, 6,      9,  23, 0,  0);
    run(1, 12,         18,     2, 9,      9,  24, 0,  0);
    run(1, 1,          1,      0, 1,      5,  25, 0,  0);
    run(1, 255,        85,     2, 7,      7,  26, 0,  0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
